// File: rtl/ru_lsu_pkg.sv
// Shared types, funct3 encodings and alignment helper for the ru_lsu load/store unit.
package ru_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RESP,
        FLT
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halfwords need 2-byte alignment and words 4-byte; bytes can never be misaligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ru_lsu_lane.sv
// Byte-lane datapath: merges store data into a read word and extracts/extends load data.
module ru_lsu_lane
    import ru_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Only the addressed lanes change; everything else keeps the RAM's current contents.
    always_comb begin
        merged = word;
        case (funct3)
            F3_B, F3_BU: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            F3_H, F3_HU: begin
                if (addr_lo[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            F3_W:    merged = wdata;
            default: merged = word;
        endcase
    end

    always_comb begin
        extracted = '0;
        case (funct3)
            F3_B:    extracted = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   extracted = {24'h0, byte_sel};
            F3_H:    extracted = {{16{half_sel[15]}}, half_sel};
            F3_HU:   extracted = {16'h0, half_sel};
            F3_W:    extracted = word;
            default: extracted = '0;
        endcase
    end

endmodule

// File: rtl/ru_lsu.sv
// Load/store unit between the core's execute stage and the word-addressed data RAM.
// Sub-word stores are read-modify-write because the RAM only writes whole words.
module ru_lsu
    import ru_lsu_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    input  logic        ram_busy
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH);

    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_fault;
    logic [31:0] lane_word;
    logic [31:0] lane_merged;
    logic [31:0] lane_extracted;

    // Evaluated on the live request so a bad access is rejected without touching the RAM.
    always_comb begin
        req_fault = is_misaligned(req_funct3, req_addr[1:0])
                  || (req_funct3 inside {3'b011, 3'b110, 3'b111})
                  || (req_write && (req_funct3 inside {F3_BU, F3_HU}))
                  || ({1'b0, req_addr} >= ADDR_LIMIT);
    end

    // In RD the lane works on the live RAM word (load extract); afterwards on the buffer (merge).
    assign lane_word = (state_q == RD) ? ram_rdata : buf_q;

    ru_lsu_lane u_lane (
        .word      (lane_word),
        .addr_lo   (addr_q[1:0]),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .merged    (lane_merged),
        .extracted (lane_extracted)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        rdata_d  = rdata_q;
        stall    = 1'b0;
        done     = 1'b0;
        fault    = 1'b0;
        ram_we   = 1'b0;

        case (state_q)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    if (req_fault) begin
                        state_d = FLT;
                    end else if (req_write && (req_funct3 == F3_W)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                stall = 1'b1;
                if (!ram_busy) begin
                    buf_d = ram_rdata;
                    if (write_q) begin
                        state_d = WR;
                    end else begin
                        rdata_d = lane_extracted;
                        state_d = RESP;
                    end
                end
            end
            WR: begin
                stall  = 1'b1;
                ram_we = 1'b1;
                if (!ram_busy) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            FLT: begin
                done    = 1'b1;
                fault   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign ram_addr  = {addr_q[31:2], 2'b00};
    assign ram_wdata = (state_q == WR) ? lane_merged : '0;

endmodule

// File: tb/tb_ru_lsu.sv
// Self-checking bench for ru_lsu: directed vector table, reset-abort sequence and
// randomized accesses checked against a byte-array memory model.
module tb_ru_lsu;
    import ru_lsu_pkg::*;

    localparam int DEPTH = 32;

    logic        clk;
    logic        nRst;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        ram_busy;

    logic [31:0] ram [DEPTH];
    logic [7:0]  ref_mem [4*DEPTH];

    int checks = 0;
    int failures = 0;

    int          res_lat;
    int          res_we;
    logic [31:0] res_rdata;
    logic        res_fault;
    logic [31:0] res_wword;
    logic        res_overlap;
    logic        res_stall_ok;
    logic        res_idle_ok;
    logic        res_timeout;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [15:0] busy;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t vecs[$];

    ru_lsu #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rdata      (rdata),
        .stall      (stall),
        .done       (done),
        .fault      (fault),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .ram_busy   (ram_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ram_rdata = (ram_addr[31:2] < DEPTH) ? ram[ram_addr[6:2]] : 32'h0;

    always @(posedge clk) begin
        if (ram_we && !ram_busy && (ram_addr[31:2] < DEPTH)) begin
            ram[ram_addr[6:2]] <= ram_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic setWord(input int idx, input logic [31:0] val);
        ram[idx] = val;
        for (int k = 0; k < 4; k++) ref_mem[4*idx+k] = val[8*k +: 8];
    endtask

    function automatic logic [31:0] refWord(input int idx);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_mem[4*idx+k];
        return v;
    endfunction

    // Reference behaviour from the access rules: size/alignment/range checks, byte-level
    // memory update, and latency as one cycle per required RAM phase plus busy stalls.
    task automatic modelOp(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [15:0] busy_pat,
                           output logic e_fault, output logic [31:0] e_rdata,
                           output int e_lat, output int e_we);
        int     size;
        int     remaining;
        int     c;
        longint val;
        logic   bsy;
        size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        e_fault = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
                || (w && f3[2]) || ((a % size) != 0) || (64'(a) >= 64'(4*DEPTH));
        e_rdata = '0;
        if (!e_fault) begin
            if (w) begin
                for (int k = 0; k < size; k++) ref_mem[a+k] = wd[8*k +: 8];
            end else begin
                val = 0;
                for (int k = 0; k < size; k++) val = val + (longint'(ref_mem[a+k]) << (8*k));
                if (!f3[2] && size < 4 && val[8*size-1]) val = val - (longint'(1) << (8*size));
                e_rdata = 32'(val);
            end
        end
        remaining = e_fault ? 0 : ((!w || size == 4) ? 1 : 2);
        e_we = 0;
        c = 0;
        while (remaining > 0) begin
            c++;
            bsy = (c < 16) ? busy_pat[4'(c)] : 1'b0;
            if (w && remaining == 1) e_we++;
            if (!bsy) remaining--;
        end
        e_lat = c + 1;
    endtask

    // Drives one request, scrambles the req_* fields after acceptance (the LSU must have
    // latched them), and records latency, response and RAM write activity.
    task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [15:0] busy_pat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        ram_busy   = 1'b0;
        #1;
        res_stall_ok = (stall === 1'b1) && (done === 1'b0);
        res_lat = 0; res_we = 0; res_rdata = '0; res_fault = 1'b0;
        res_wword = '0; res_overlap = 1'b0; res_timeout = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_funct3 = 3'($urandom);
            req_write  = 1'($urandom);
            ram_busy   = (c < 16) ? busy_pat[4'(c)] : 1'b0;
            #1;
            if (ram_we) begin
                res_we++;
                if (!ram_busy) res_wword = ram_wdata;
            end
            if (done) begin
                res_lat = c; res_rdata = rdata; res_fault = fault;
                res_overlap = ram_we;
                if (stall) res_stall_ok = 1'b0;
                res_timeout = 1'b0;
                break;
            end else if (!stall) begin
                res_stall_ok = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        ram_busy  = 1'b0;
        #1;
        res_idle_ok = !stall && !done && !ram_we;
    endtask

    task automatic checkOp(input string name, input logic [31:0] e_rdata, input logic e_fault,
                           input int e_lat, input int e_we, input logic [31:0] e_wword);
        if (res_timeout) begin
            checkOutput({name, " timeout"}, 32'd1, 32'd0);
            return;
        end
        checkOutput({name, " latency"}, 32'(res_lat), 32'(e_lat));
        checkOutput({name, " rdata"}, res_rdata, e_rdata);
        checkOutput({name, " fault"}, 32'(res_fault), 32'(e_fault));
        checkOutput({name, " we_cycles"}, 32'(res_we), 32'(e_we));
        checkOutput({name, " we_with_done"}, 32'(res_overlap), 32'd0);
        checkOutput({name, " stall"}, 32'(res_stall_ok), 32'd1);
        checkOutput({name, " back_to_idle"}, 32'(res_idle_ok), 32'd1);
        if (e_we > 0) checkOutput({name, " ram_wdata"}, res_wword, e_wword);
    endtask

    initial begin
        logic        e_fault;
        logic [31:0] e_rdata;
        int          e_lat;
        int          e_we;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [15:0] busy;
        int          sel;
        int          bad;

        //          w  f3     addr   wdata          busy      rdata          flt lat we wword
        vecs.push_back('{1'b0, F3_B,  32'h0B, 32'h0,        16'h0000, 32'hFFFFFF88, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{1'b0, F3_HU, 32'h0A, 32'h0,        16'h0000, 32'h00008899, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{1'b0, F3_H,  32'h08, 32'h0,        16'h0000, 32'hFFFFAABB, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{1'b1, F3_B,  32'h09, 32'h123456CC, 16'h0000, 32'h0,        1'b0, 3, 1, 32'h8899CCBB});
        vecs.push_back('{1'b0, F3_W,  32'h08, 32'h0,        16'h0000, 32'h8899CCBB, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{1'b0, F3_W,  32'h06, 32'h0,        16'h0000, 32'h0,        1'b1, 1, 0, 32'h0});
        vecs.push_back('{1'b1, F3_H,  32'h05, 32'hFFFFFFFF, 16'h0000, 32'h0,        1'b1, 1, 0, 32'h0});
        vecs.push_back('{1'b1, F3_W,  32'h80, 32'hCAFEF00D, 16'h0000, 32'h0,        1'b1, 1, 0, 32'h0});
        vecs.push_back('{1'b0, F3_W,  32'h04, 32'h0,        16'h000E, 32'h11223344, 1'b0, 5, 0, 32'h0});
        vecs.push_back('{1'b1, F3_W,  32'h0C, 32'hDEADBEEF, 16'h0006, 32'h0,        1'b0, 4, 3, 32'hDEADBEEF});
        vecs.push_back('{1'b0, F3_W,  32'h0C, 32'h0,        16'h0000, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{1'b1, F3_H,  32'h0E, 32'hFFFF1234, 16'h0004, 32'h0,        1'b0, 4, 2, 32'h1234BEEF});
        vecs.push_back('{1'b0, F3_W,  32'h0C, 32'h0,        16'h0000, 32'h1234BEEF, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{1'b0, F3_BU, 32'h0B, 32'h0,        16'h0000, 32'h00000088, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{1'b0, 3'b011, 32'h00, 32'h0,       16'h0000, 32'h0,        1'b1, 1, 0, 32'h0});
        vecs.push_back('{1'b1, F3_BU, 32'h10, 32'h77,       16'h0000, 32'h0,        1'b1, 1, 0, 32'h0});
        vecs.push_back('{1'b0, F3_W,  32'h7C, 32'h0,        16'h0000, 32'h0,        1'b0, 2, 0, 32'h0});
        vecs.push_back('{1'b0, F3_B,  32'h80, 32'h0,        16'h0000, 32'h0,        1'b1, 1, 0, 32'h0});
        vecs.push_back('{1'b1, F3_B,  32'h7F, 32'h000000A5, 16'h0000, 32'h0,        1'b0, 3, 1, 32'hA5000000});
        vecs.push_back('{1'b0, F3_B,  32'h7F, 32'h0,        16'h0000, 32'hFFFFFFA5, 1'b0, 2, 0, 32'h0});

        nRst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; ram_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) setWord(i, 32'h0);
        setWord(1, 32'h11223344);
        setWord(2, 32'h8899AABB);
        setWord(4, 32'h55667788);

        repeat (3) @(negedge clk);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset fault", 32'(fault), 32'd0);
        checkOutput("reset ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset ram_addr", ram_addr, 32'h0);
        checkOutput("reset rdata", rdata, 32'h0);
        nRst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            modelOp(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].busy, e_fault, e_rdata, e_lat, e_we);
            applyStimulus(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].busy);
            checkOp($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_fault,
                    vecs[i].exp_lat, vecs[i].exp_we, vecs[i].exp_wword);
        end
        checkOutput("faulted stores left word2", ram[2], 32'h8899CCBB);

        // Reset while an SB sits in WR (RAM held busy): the write must never land.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_B;
        req_addr = 32'h10; req_wdata = 32'h000000EE; ram_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        ram_busy = 1'b1;
        #1;
        checkOutput("rst_seq we_in_wr", 32'(ram_we), 32'd1);
        nRst = 1'b0;
        #1;
        checkOutput("rst_seq we_async_drop", 32'(ram_we), 32'd0);
        req_valid = 1'b0;
        ram_busy  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nRst = 1'b1;
        #1;
        checkOutput("rst_seq stall", 32'(stall), 32'd0);
        checkOutput("rst_seq done", 32'(done), 32'd0);
        checkOutput("rst_seq ram_addr", ram_addr, 32'h0);
        checkOutput("rst_seq rdata", rdata, 32'h0);
        checkOutput("rst_seq word_unchanged", ram[4], 32'h55667788);
        modelOp(1'b0, F3_W, 32'h10, 32'h0, 16'h0, e_fault, e_rdata, e_lat, e_we);
        applyStimulus(1'b0, F3_W, 32'h10, 32'h0, 16'h0);
        checkOp("rst_seq reload", e_rdata, e_fault, e_lat, e_we, 32'h0);

        for (int n = 0; n < 150; n++) begin
            w   = 1'($urandom);
            f3  = 3'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 8) a = 32'($urandom_range(0, 4*DEPTH-1));
            else if (sel == 8) a = 32'($urandom_range(4*DEPTH-4, 4*DEPTH+3));
            else a = $urandom;
            wd   = $urandom;
            busy = 16'($urandom & $urandom) & 16'hFFFE;
            modelOp(w, f3, a, wd, busy, e_fault, e_rdata, e_lat, e_we);
            applyStimulus(w, f3, a, wd, busy);
            checkOp($sformatf("rand%0d", n), e_rdata, e_fault, e_lat, e_we,
                    (a < 32'(4*DEPTH)) ? refWord(int'(a[6:2])) : 32'h0);
        end

        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram[i] !== refWord(i)) bad++;
        end
        checkOutput("final memory mismatched words", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ru_lsu.md
Name: ru_lsu

Overview:
Load/store unit between the single-cycle core's execute stage and the word-addressed data RAM (ru_ram). It accepts one memory instruction at a time and handles byte, halfword and word granularity. Sub-word stores are done as read-modify-write, because the RAM only writes whole words. Loads are sign- or zero-extended, misaligned, illegal and out-of-range accesses are faulted, and the core is stalled until the access completes.

Parameters:
DEPTH, 32, number of 32-bit words in the data RAM; accesses with byte address >= 4*DEPTH fault.

Ports:
clk  in  1  clock
nRst  in  1  asynchronous active-low reset
req_valid  in  1  core presents a load/store; held stable while stall=1
req_write  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
rdata  out  32  extended load result, valid when done=1
stall  out  1  core must hold the current instruction
done  out  1  one-cycle pulse: access finished (or faulted)
fault  out  1  qualifies done: access rejected, no RAM write occurred
ram_addr  out  32  byte address to the RAM, always word-aligned ({addr[31:2],2'b00})
ram_wdata  out  32  merged store word
ram_we  out  1  RAM write enable
ram_rdata  in  32  combinational RAM read data for ram_addr
ram_busy  in  1  RAM not ready; the current state holds while high

Behaviour:
- Reset (nRst low, asynchronous):
  - State goes to IDLE; latched request registers, read buffer and rdata clear to 0.
  - stall=0, done=0, fault=0, ram_we=0, ram_addr=0.
  - Reset mid-operation aborts the access; ram_we drops immediately and no partial write is issued.
- Request latch: on acceptance in IDLE, addr, funct3, write and wdata are captured. Later changes on the req_* inputs are ignored until the next IDLE.
- Fault check in IDLE, combinational on the req_* inputs. Any one of these faults the access:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - funct3 in {011, 110, 111};
  - store with funct3 100 or 101;
  - addr >= 4*DEPTH.
- FSM states: IDLE, RD, WR, RESP, FLT.
  - IDLE:
    - req_valid and fault -> FLT.
    - load -> RD.
    - store word -> WR.
    - store B/H -> RD.
    - stall = req_valid.
  - RD:
    - ram_addr = latched word address.
    - If ram_busy=0, capture ram_rdata into the read buffer; load -> RESP, store -> WR.
    - If ram_busy=1, hold.
    - stall=1.
  - WR:
    - ram_we=1.
    - ram_wdata = buffer with the selected lanes replaced by wdata[7:0] (B, lane addr[1:0]) or wdata[15:0] (H, lanes addr[1]*2+1:addr[1]*2). Store word uses wdata directly.
    - If ram_busy=0 -> RESP. If ram_busy=1, hold with ram_we=1.
    - stall=1.
  - RESP:
    - done=1, stall=0, fault=0, returns to IDLE unconditionally.
    - rdata is the extracted lane: B/H sign-extended, BU/HU zero-extended, W unchanged. rdata is 0 for stores.
  - FLT: done=1, fault=1, stall=0, rdata=0, no RAM access; -> IDLE.
- Latency (ram_busy=0), counted from the accept edge to the done cycle:
  - load or store word: 2 cycles;
  - sub-word store: 3 cycles;
  - fault: 1 cycle.
  - Each busy cycle adds 1.
- Back-to-back: the core advances during RESP/FLT, so a request seen in IDLE the next cycle is a new instruction. Any req_valid during RESP/FLT is ignored.
- ram_we is high only in WR. It is never high in the same cycle as done.

Decomposition:
- Package ru_lsu_pkg holds:
  - lsu_state_t enum (IDLE, RD, WR, RESP, FLT);
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - helper function is_misaligned(funct3, addr[1:0]).
- One combinational sub-module, ru_lsu_lane, performs the store-lane merge and the load extract/extend from (word, addr[1:0], funct3, wdata).
- The top level keeps the FSM and registers.

Test Plan:
- Preload RAM[2]=0x8899AABB. LB addr 0x0B -> done 2 cycles after accept, rdata=0xFFFFFF88, fault=0, ram_we never high.
- Same word, LHU addr 0x0A -> rdata=0x00008899. LH addr 0x08 -> rdata=0xFFFFAABB.
- SB addr 0x09 wdata=0x123456CC -> RD then WR with ram_wdata=0x8899CCBB and ram_we high exactly 1 cycle; done at cycle 3; subsequent LW 0x08 returns 0x8899CCBB.
- LW addr 0x06, then SH addr 0x05, then SW addr 0x80 (DEPTH=32) -> each gives done=fault=1 one cycle after accept, ram_we stays 0, RAM unchanged.
- LW 0x04 with ram_busy high for 3 cycles in RD -> stall held, done at cycle 5, rdata correct; SW with busy in WR -> ram_we held through busy, single logical write.
- Assert nRst low during WR of an SB -> ram_we falls asynchronously, the target word is unchanged, state is IDLE and outputs are at reset values after release.
